// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and helpers for the pixel pack writer
package pixel_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pw_state_t;

  localparam int BYTEENABLEWIDTH = 4;
  localparam int LANE_BITS       = 2;

  // Byte enables covering lanes 0..lane inclusive.
  function automatic logic [BYTEENABLEWIDTH-1:0] lanes_to_be(input logic [LANE_BITS-1:0] lane);
    logic [BYTEENABLEWIDTH-1:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - small synchronous FIFO holding packed words with byte enables
module word_fifo
  import pixel_pkg::*;
#(
  parameter int WIDTH = 32 + BYTEENABLEWIDTH,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + CW'(1);
    else if (do_pop && !do_push)
      count_next = count - CW'(1);
  end

  // Memory is cleared on reset so the head word reads zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/pixel_pack_writer.sv
// rtl/pixel_pack_writer.sv - packs 8-bit pixels into 32-bit words and writes them over Avalon-MM
module pixel_pack_writer
  import pixel_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 28,
  parameter int DATAWIDTH           = 32,
  parameter int FIFO_DEPTH          = 4,
  parameter int COUNTWIDTH          = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_addr,
  input  logic [COUNTWIDTH-1:0]          pixel_count,
  input  logic [7:0]                     pix_data,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic                           busy,
  output logic                           done,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic [BYTEENABLEWIDTH-1:0]     master_byteenable,
  output logic                           master_write,
  input  logic                           master_waitrequest
);

  localparam int FW = DATAWIDTH + BYTEENABLEWIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pw_state_t                    state;
  pw_state_t                    state_next;
  logic [MASTER_ADDRESSWIDTH-1:0] addr_q;
  logic [COUNTWIDTH-1:0]        count_q;
  logic [COUNTWIDTH-1:0]        recv_q;
  logic [COUNTWIDTH-1:0]        recv_inc;
  logic [DATAWIDTH-1:0]         pack_q;
  logic [DATAWIDTH-1:0]         word_next;
  logic [LANE_BITS-1:0]         lane_q;

  logic                         accept;
  logic                         last_pix;
  logic                         push;
  logic                         pop;
  logic [FW-1:0]                push_data;
  logic [FW-1:0]                fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CW-1:0]                fifo_count;

  assign accept    = pix_valid && pix_ready;
  assign recv_inc  = recv_q + 1'b1;
  assign last_pix  = accept && (recv_inc == count_q);
  assign push      = accept && ((lane_q == LANE_BITS'(3)) || last_pix);
  assign push_data = {lanes_to_be(lane_q), word_next};
  assign pop       = master_write && !master_waitrequest;

  always_comb begin
    word_next = pack_q;
    word_next[{lane_q, 3'b000} +: 8] = pix_data;
  end

  word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The FIFO only holds words while a frame is active, so non-empty means a write is pending.
  assign master_write      = !fifo_empty;
  assign master_writedata  = fifo_head[DATAWIDTH-1:0];
  assign master_byteenable = fifo_head[FW-1:DATAWIDTH];
  assign master_address    = addr_q;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pix_ready = (state == RUN) && !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (pixel_count == '0) ? DONE : RUN;
      RUN:   if (last_pix) state_next = DRAIN;
      // Leave as soon as the final word is accepted so done follows it by one cycle.
      DRAIN: if (fifo_empty || (pop && fifo_count == CW'(1))) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      count_q <= '0;
      recv_q  <= '0;
      pack_q  <= '0;
      lane_q  <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_q  <= {base_addr[MASTER_ADDRESSWIDTH-1:2], 2'b00};
        count_q <= pixel_count;
        recv_q  <= '0;
        pack_q  <= '0;
        lane_q  <= '0;
      end
      if (accept) begin
        recv_q <= recv_inc;
        lane_q <= lane_q + 1'b1;
        pack_q <= push ? '0 : word_next;
      end
      if (pop)
        addr_q <= addr_q + MASTER_ADDRESSWIDTH'(4);
    end
  end

endmodule

// File: tb/tb_pixel_pack_writer.sv
// tb/tb_pixel_pack_writer.sv - directed bench for pixel_pack_writer
module tb_pixel_pack_writer;

  typedef struct {
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [27:0] base;
    logic [23:0] cnt;
    logic [7:0]  pix0;
    int          stall;
    int          first;
    int          nexp;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] base_addr = '0;
  logic [23:0] pixel_count = '0;
  logic [7:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic [27:0] master_address;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        master_write;
  logic        master_waitrequest = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  wr_t    got[$];
  wr_t    exp_tab[$];
  frame_t frames[$];

  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  int          stall_checked = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [27:0] prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_be;

  pixel_pack_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .base_addr          (base_addr),
    .pixel_count        (pixel_count),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .busy               (busy),
    .done               (done),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_byteenable  (master_byteenable),
    .master_write       (master_write),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (master_write && !master_waitrequest) begin
      got.push_back('{master_address, master_writedata, master_byteenable});
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && master_write && !reset) begin
      stall_checked++;
      if (master_address !== prev_addr || master_writedata !== prev_data ||
          master_byteenable !== prev_be)
        stall_viol++;
    end
    prev_stall = master_write && master_waitrequest && !reset;
    prev_addr  = master_address;
    prev_data  = master_writedata;
    prev_be    = master_byteenable;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input frame_t f);
    int  idx;
    int  cycles;
    int  d0;
    int  g0;
    logic hs;
    logic [31:0] mask;
    wr_t w;
    wr_t e;
    d0 = done_cnt;
    g0 = got.size();
    @(posedge clk); #1;
    start = 1'b1; base_addr = f.base; pixel_count = f.cnt;
    master_waitrequest = (f.stall > 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    idx = 0;
    cycles = 0;
    while (done_cnt == d0 && cycles < 400) begin
      pix_valid = (idx < int'(f.cnt));
      pix_data = 8'(int'(f.pix0) + idx);
      master_waitrequest = (cycles < f.stall);
      if (f.stall > 0 && cycles == f.stall) begin
        check("stall_pixels_accepted", 64'(idx), 64'd16);
        check("stall_pix_ready_low", 64'(pix_ready), 64'd0);
      end
      @(negedge clk);
      hs = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cycles++;
    end
    pix_valid = 1'b0;
    master_waitrequest = 1'b0;
    if (done_cnt == d0) begin
      miscompares++;
      vectors++;
      $display("FAIL done_timeout: no done pulse within 400 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("write_count", 64'(got.size() - g0), 64'(f.nexp));
    if (f.nexp > 0)
      check("done_after_last_write", 64'(done_cyc), 64'(last_wr_cyc + 1));
    for (int k = 0; k < f.nexp && g0 + k < got.size(); k++) begin
      w = got[g0 + k];
      e = exp_tab[f.first + k];
      mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
      check("wr_addr", 64'(w.addr), 64'(e.addr));
      check("wr_be", 64'(w.be), 64'(e.be));
      check("wr_data", 64'(w.data & mask), 64'(e.data & mask));
    end
  endtask

  initial begin
    int sfirst;
    logic [31:0] word;
    exp_tab.push_back('{28'h8500000, 32'h04030201, 4'hF});
    exp_tab.push_back('{28'h8500004, 32'h08070605, 4'hF});
    frames.push_back('{28'h8500000, 24'd8, 8'h01, 0, 0, 2});
    exp_tab.push_back('{28'h0000100, 32'h04030201, 4'hF});
    exp_tab.push_back('{28'h0000104, 32'h00000605, 4'b0011});
    frames.push_back('{28'h0000100, 24'd6, 8'h01, 0, 2, 2});
    exp_tab.push_back('{28'hFFFFFFC, 32'h14131211, 4'hF});
    exp_tab.push_back('{28'h0000000, 32'h18171615, 4'hF});
    frames.push_back('{28'hFFFFFFC, 24'd8, 8'h11, 0, 4, 2});
    exp_tab.push_back('{28'h0000200, 32'hA3A2A1A0, 4'hF});
    exp_tab.push_back('{28'h0000204, 32'h000000A4, 4'b0001});
    frames.push_back('{28'h0000203, 24'd5, 8'hA0, 0, 6, 2});
    exp_tab.push_back('{28'h0000040, 32'h00323130, 4'b0111});
    frames.push_back('{28'h0000040, 24'd3, 8'h30, 0, 8, 1});
    frames.push_back('{28'h0000080, 24'd0, 8'h00, 0, 9, 0});
    sfirst = exp_tab.size();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++)
        word[j*8 +: 8] = 8'(8'h40 + 4 * k + j);
      exp_tab.push_back('{28'(28'h0001000 + 4 * k), word, 4'hF});
    end
    frames.push_back('{28'h0001000, 24'd32, 8'h40, 20, sfirst, 8});
    exp_tab.push_back('{28'h0000300, 32'h53525150, 4'hF});

    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_write", 64'(master_write), 64'd0);
    check("rst_address", 64'(master_address), 64'd0);
    check("rst_writedata", 64'(master_writedata), 64'd0);
    check("rst_byteenable", 64'(master_byteenable), 64'd0);
    reset = 1'b0;

    foreach (frames[i]) run_frame(frames[i]);
    check("stall_cycles_seen", 64'(stall_checked >= 15), 64'd1);
    check("stall_hold_violations", 64'(stall_viol), 64'd0);

    @(posedge clk); #1;
    start = 1'b1; base_addr = 28'h0000500; pixel_count = 24'd8;
    master_waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix_data = 8'(8'hE0 + i);
      @(posedge clk); #1;
    end
    check("pre_reset_write_pending", 64'(master_write), 64'd1);
    reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    check("midrst_write", 64'(master_write), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_pix_ready", 64'(pix_ready), 64'd0);
    check("midrst_byteenable", 64'(master_byteenable), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    master_waitrequest = 1'b0;
    run_frame('{28'h0000300, 24'd4, 8'h50, 0, exp_tab.size() - 1, 1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
